// File: rtl/sram_portb_dma.sv
// Read-DMA engine for port B of the shared data SRAM.
// Streams a contiguous block of 32-bit words from SRAM into a valid/ready
// stream. Reads are only issued when a FIFO slot is guaranteed for the
// returning data, so back-pressure never drops a word.
module sram_portb_dma #(
    parameter int ADDR_W = 13,
    parameter int LEN_W  = 14,
    parameter int RD_LAT = 2,
    parameter int DEPTH  = 4
) (
    input  logic              pll_core_cpuclk,
    input  logic              pad_cpu_rst_b,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [LEN_W-1:0]  cfg_len,
    output logic              busy,
    output logic              done,
    output logic [15:0]       dram1_portb_addr,
    output logic [3:0]        dram1_portb_wen,
    output logic [31:0]       dram1_portb_din,
    input  logic [31:0]       dram1_portb_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [31:0]       m_data,
    output logic              m_last
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Wide enough for in-flight reads plus FIFO occupancy.
    localparam int CNT_W = $clog2(DEPTH + RD_LAT + 2);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   base_reg;
    logic [LEN_W-1:0]    len_reg;
    logic [LEN_W-1:0]    issued_reg;
    logic [LEN_W-1:0]    popped_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [RD_LAT:0]     vpipe_reg;
    logic [31:0]         fifo_mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg;
    logic [PTR_W-1:0]    rd_ptr_reg;
    logic [CNT_W-1:0]    fifo_cnt_reg;
    logic [CNT_W-1:0]    inflight;
    logic [CNT_W:0]      occupancy;
    logic [CNT_W:0]      credit_limit;
    logic [LEN_W-1:0]    len_m1;
    logic                accept;
    logic                issue;
    logic                pop;
    logic                fifo_wr;
    logic                last_pop;

    // Port B is read-only from this engine.
    assign dram1_portb_wen  = 4'b0000;
    assign dram1_portb_din  = 32'd0;
    assign dram1_portb_addr = 16'(addr_reg);

    assign len_m1   = len_reg - LEN_ONE;
    assign accept   = (state_reg == ST_IDLE) && start;
    assign m_valid  = (fifo_cnt_reg != '0);
    assign m_data   = fifo_mem[rd_ptr_reg];
    assign m_last   = m_valid && (popped_reg == len_m1);
    assign pop      = m_valid && m_ready;
    assign fifo_wr  = vpipe_reg[RD_LAT];
    assign last_pop = pop && (popped_reg == len_m1);
    assign busy     = (state_reg == ST_RUN);
    assign done     = (state_reg == ST_FIN);

    // Count reads still travelling through the SRAM pipeline.
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= RD_LAT; i++) begin
            inflight = inflight + {{(CNT_W-1){1'b0}}, vpipe_reg[i]};
        end
    end

    // Issue only when the word is guaranteed a FIFO slot; a pop this cycle
    // returns its slot immediately so the stream keeps one word per cycle.
    always_comb begin
        occupancy    = {1'b0, inflight} + {1'b0, fifo_cnt_reg};
        credit_limit = (CNT_W+1)'(DEPTH) + {{CNT_W{1'b0}}, pop};
        issue        = (state_reg == ST_RUN) && (issued_reg < len_reg) &&
                       (occupancy < credit_limit);
    end

    // FSM state register.
    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) state_reg <= ST_IDLE;
        else                state_reg <= state_next;
    end

    // FSM next state: a zero-length request goes straight to the done pulse.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = (cfg_len != '0) ? ST_RUN : ST_FIN;
            ST_RUN:  if (last_pop) state_next = ST_FIN;
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Transfer configuration and progress counters; start is ignored unless idle.
    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            base_reg   <= '0;
            len_reg    <= '0;
            issued_reg <= '0;
            popped_reg <= '0;
        end else if (accept) begin
            base_reg   <= cfg_base;
            len_reg    <= cfg_len;
            issued_reg <= '0;
            popped_reg <= '0;
        end else begin
            if (issue) issued_reg <= issued_reg + LEN_ONE;
            if (pop)   popped_reg <= popped_reg + LEN_ONE;
        end
    end

    // Registered port-B address and the read-valid pipeline aligned to dout.
    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            addr_reg  <= '0;
            vpipe_reg <= '0;
        end else begin
            if (issue) addr_reg <= base_reg + issued_reg[ADDR_W-1:0];
            vpipe_reg <= {vpipe_reg[RD_LAT-1:0], issue};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fifo_cnt_reg <= '0;
        end else begin
            if (fifo_wr) wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_ONE;
            if (pop)     rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_ONE;
            case ({fifo_wr, pop})
                2'b10:   fifo_cnt_reg <= fifo_cnt_reg + CNT_ONE;
                2'b01:   fifo_cnt_reg <= fifo_cnt_reg - CNT_ONE;
                default: fifo_cnt_reg <= fifo_cnt_reg;
            endcase
        end
    end

    // FIFO storage, one resettable word register per slot.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fifo
            // Capture returning read data into the slot under the write pointer.
            always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
                if (!pad_cpu_rst_b)
                    fifo_mem[gi] <= '0;
                else if (fifo_wr && (wr_ptr_reg == PTR_W'(gi)))
                    fifo_mem[gi] <= dram1_portb_dout;
            end
        end
    endgenerate

endmodule

// File: tb/tb_sram_portb_dma.sv
// Self-checking bench for sram_portb_dma: vector table plus reset sequence,
// stream words checked against a scoreboard queue.
module tb_sram_portb_dma;

    localparam int DEPTH  = 4;
    localparam int RD_LAT = 2;

    logic        pll_core_cpuclk = 1'b0;
    logic        pad_cpu_rst_b   = 1'b0;
    logic        start           = 1'b0;
    logic [12:0] cfg_base        = '0;
    logic [13:0] cfg_len         = '0;
    logic        busy;
    logic        done;
    logic [15:0] dram1_portb_addr;
    logic [3:0]  dram1_portb_wen;
    logic [31:0] dram1_portb_din;
    logic [31:0] dram1_portb_dout;
    logic        m_valid;
    logic        m_ready         = 1'b0;
    logic [31:0] m_data;
    logic        m_last;

    sram_portb_dma dut (
        .pll_core_cpuclk  (pll_core_cpuclk),
        .pad_cpu_rst_b    (pad_cpu_rst_b),
        .start            (start),
        .cfg_base         (cfg_base),
        .cfg_len          (cfg_len),
        .busy             (busy),
        .done             (done),
        .dram1_portb_addr (dram1_portb_addr),
        .dram1_portb_wen  (dram1_portb_wen),
        .dram1_portb_din  (dram1_portb_din),
        .dram1_portb_dout (dram1_portb_dout),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_data           (m_data),
        .m_last           (m_last)
    );

    always #5 pll_core_cpuclk = ~pll_core_cpuclk;

    // SRAM model: two-cycle registered read, always enabled.
    logic [31:0] mem [8192];
    logic [31:0] rd_stage;
    initial for (int i = 0; i < 8192; i++) mem[i] = 32'hA000_0000 + 32'(i);
    always @(posedge pll_core_cpuclk) begin
        rd_stage         <= mem[dram1_portb_addr[12:0]];
        dram1_portb_dout <= rd_stage;
    end

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    typedef struct {
        logic [12:0] base;
        logic [13:0] len;
        int          mode;          // 0 ready=1, 1 toggle+stall, 2 random
        int          restart_t;     // cycle of a stray start pulse, 0 = none
        int          exp_first_lat; // cycles start->first m_valid, -1 = never
        int          exp_done_lat;  // cycles start->done, -1 = not fixed
    } vec_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   first_valid_cyc = -1;
    int   last_hs_cyc = -1;
    int   hs_cnt = 0;
    int   done_total = 0;
    int   max_occ = 0;
    logic prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    function automatic logic [31:0] exp_word(input logic [12:0] a);
        return 32'hA000_0000 + 32'(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic ready_at(input int mode, input int t);
        logic r;
        r = 1'b1;
        if (mode == 1) begin
            case (t % 4)
                0: r = 1'b1;
                1: r = 1'b0;
                2: r = 1'b0;
                default: r = 1'b1;
            endcase
            if (t >= 8 && t < 13) r = 1'b0;
        end else if (mode == 2) begin
            r = 1'($urandom_range(0, 1));
        end
        return r;
    endfunction

    always @(posedge pll_core_cpuclk) cyc <= cyc + 1;

    // Stream monitor: handshakes against the scoreboard, hold rule, credit bound.
    always @(negedge pll_core_cpuclk) begin
        int   occ;
        exp_t e;
        if (!pad_cpu_rst_b) begin
            prev_stall = 1'b0;
        end else begin
            occ = int'(dut.inflight) + int'(dut.fifo_cnt_reg);
            if (occ > max_occ) max_occ = occ;
            if (occ > DEPTH) chk("credit_occupancy", 32'(occ), 32'(DEPTH));
            if (done) done_total++;
            if (prev_stall) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_data", m_data, prev_data);
            end
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (m_valid && m_ready) begin
                hs_cnt++;
                last_hs_cyc = cyc;
                if (sb_q.size() == 0) begin
                    chk("unexpected_word", m_data, 32'hxxxx_xxxx);
                end else begin
                    e = sb_q.pop_front();
                    $display("word data=%h last=%0b (expected %h last=%0b)", m_data, m_last, e.data, e.last);
                    chk("word_data", m_data, e.data);
                    chk("word_last", 32'(m_last), 32'(e.last));
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic run_vec(input vec_t v);
        int start_cyc;
        int done_cyc;
        int extra;
        done_cyc = -1;
        for (int i = 0; i < int'(v.len); i++)
            sb_q.push_back('{data: exp_word(v.base + 13'(i)), last: (i == int'(v.len) - 1)});
        first_valid_cyc = -1;
        @(posedge pll_core_cpuclk); #1;
        start = 1'b1; cfg_base = v.base; cfg_len = v.len;
        start_cyc = cyc;
        m_ready = ready_at(v.mode, 0);
        for (int t = 1; t <= 300; t++) begin
            @(posedge pll_core_cpuclk); #1;
            start = (v.restart_t == t);
            cfg_base = start ? 13'h0555 : 13'h1ABC;
            cfg_len  = start ? 14'd3 : 14'd7;
            m_ready = ready_at(v.mode, t);
            if (t == 1 && v.len != 0) chk("busy_after_start", 32'(busy), 32'd1);
            if (t == 2 && v.len != 0) chk("first_addr", 32'(dram1_portb_addr), 32'(v.base));
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        start = 1'b0;
        chk("done_seen", 32'(done_cyc >= 0), 32'd1);
        chk("busy_in_fin", 32'(busy), 32'd0);
        chk("first_valid_lat", 32'(first_valid_cyc < 0 ? -1 : first_valid_cyc - start_cyc),
            32'(v.exp_first_lat));
        if (v.exp_done_lat >= 0)
            chk("done_lat", 32'(done_cyc - start_cyc), 32'(v.exp_done_lat));
        if (v.len != 0)
            chk("done_after_last_hs", 32'(done_cyc - last_hs_cyc), 32'd1);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        extra = 0;
        for (int t = 0; t < 4; t++) begin
            @(posedge pll_core_cpuclk); #1;
            if (done || m_valid || busy) extra++;
        end
        chk("quiet_after_done", 32'(extra), 32'd0);
        $display("vector base=%h len=%0d mode=%0d completed", v.base, v.len, v.mode);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vecs[6];
        vec_t rv;
        int   hs0;
        int   done0;
        int   seen;

        vecs[0] = '{base: 13'h0010, len: 14'd8,  mode: 0, restart_t: 0, exp_first_lat: 5,  exp_done_lat: 13};
        vecs[1] = '{base: 13'h0010, len: 14'd8,  mode: 1, restart_t: 0, exp_first_lat: 5,  exp_done_lat: -1};
        vecs[2] = '{base: 13'h1FFE, len: 14'd4,  mode: 0, restart_t: 0, exp_first_lat: 5,  exp_done_lat: 9};
        vecs[3] = '{base: 13'h0000, len: 14'd0,  mode: 0, restart_t: 0, exp_first_lat: -1, exp_done_lat: 1};
        vecs[4] = '{base: 13'h0100, len: 14'd16, mode: 0, restart_t: 4, exp_first_lat: 5,  exp_done_lat: 21};
        vecs[5] = '{base: 13'h00A5, len: 14'd12, mode: 2, restart_t: 0, exp_first_lat: 5,  exp_done_lat: -1};

        // Reset state.
        #12;
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_done",    32'(done),    32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_last",  32'(m_last),  32'd0);
        chk("rst_m_data",  m_data,       32'd0);
        chk("rst_addr",    32'(dram1_portb_addr), 32'd0);
        chk("rst_wen",     32'(dram1_portb_wen),  32'd0);
        chk("rst_din",     dram1_portb_din,       32'd0);
        @(posedge pll_core_cpuclk); #1;
        pad_cpu_rst_b = 1'b1;
        @(posedge pll_core_cpuclk); #1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset in the middle of a 10-word transfer.
        for (int i = 0; i < 10; i++)
            sb_q.push_back('{data: exp_word(13'h0020 + 13'(i)), last: (i == 9)});
        hs0   = hs_cnt;
        done0 = done_total;
        m_ready = 1'b1;
        @(posedge pll_core_cpuclk); #1;
        start = 1'b1; cfg_base = 13'h0020; cfg_len = 14'd10;
        seen = 0;
        for (int t = 0; t < 100; t++) begin
            @(posedge pll_core_cpuclk); #1;
            start = 1'b0;
            if (hs_cnt - hs0 >= 3) begin
                seen = 1;
                break;
            end
        end
        chk("three_words_before_reset", 32'(seen), 32'd1);
        pad_cpu_rst_b = 1'b0;
        #1;
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        chk("midrst_busy",    32'(busy),    32'd0);
        chk("midrst_m_data",  m_data,       32'd0);
        chk("midrst_addr",    32'(dram1_portb_addr), 32'd0);
        sb_q.delete();
        @(posedge pll_core_cpuclk);
        @(posedge pll_core_cpuclk); #1;
        pad_cpu_rst_b = 1'b1;
        chk("midrst_no_done", 32'(done_total - done0), 32'd0);
        rv = '{base: 13'h0000, len: 14'd2, mode: 0, restart_t: 0, exp_first_lat: 5, exp_done_lat: 7};
        run_vec(rv);

        chk("credit_bound_ok", 32'(max_occ <= DEPTH), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
